// File: rtl/key_remap_decoder.sv
// Play-mode key front end: synchronize, debounce, decode against the seven
// programmed key masks and drive note_out / note_valid / note_active.
// Optional debounce stage enabled by defining KEY_REMAP_DEBOUNCE_EN.
module key_remap_decoder #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] key_in,
  input  logic [6:0] key_mapping_0,
  input  logic [6:0] key_mapping_1,
  input  logic [6:0] key_mapping_2,
  input  logic [6:0] key_mapping_3,
  input  logic [6:0] key_mapping_4,
  input  logic [6:0] key_mapping_5,
  input  logic [6:0] key_mapping_6,
  output logic [3:0] note_out,
  output logic       note_valid,
  output logic       note_active
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    GAP     = 2'd2
  } state_t;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  logic [6:0] sync1_r;
  logic [6:0] s_r;
  logic [6:0] deb_s;
  logic [6:0] hit_s;
  logic [3:0] dec_s;
  state_t     state_r;
  state_t     state_s;
  logic [3:0] note_s;
  logic [3:0] pend_r;
  logic [3:0] pend_s;
  logic       valid_s;

  // Two-flop synchronizer for the asynchronous key switches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 7'd0;
      s_r     <= 7'd0;
    end else begin
      sync1_r <= key_in;
      s_r     <= sync1_r;
    end
  end

`ifdef KEY_REMAP_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [6:0]       cand_r;
  logic [CNT_W-1:0] cnt_r;
  logic [6:0]       deb_r;

  // Stability counter: any change of s restarts it; saturates at CNT_MAX
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_r <= 7'd0;
      cnt_r  <= '0;
      deb_r  <= 7'd0;
    end else begin
      cand_r <= s_r;
      if (s_r != cand_r) begin
        cnt_r <= '0;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (cnt_r == CNT_MAX) begin
        deb_r <= cand_r;
      end else begin
        deb_r <= deb_r;
      end
    end
  end

  assign deb_s = deb_r;
`else
  assign deb_s = s_r;
`endif

  // An all-zero mask can never produce a hit
  assign hit_s[0] = |(deb_s & key_mapping_0);
  assign hit_s[1] = |(deb_s & key_mapping_1);
  assign hit_s[2] = |(deb_s & key_mapping_2);
  assign hit_s[3] = |(deb_s & key_mapping_3);
  assign hit_s[4] = |(deb_s & key_mapping_4);
  assign hit_s[5] = |(deb_s & key_mapping_5);
  assign hit_s[6] = |(deb_s & key_mapping_6);

  // Lowest-numbered hitting mapping wins
  always_comb begin
    dec_s = 4'd0;
    casez (hit_s)
      7'b??????1: dec_s = 4'd1;
      7'b?????10: dec_s = 4'd2;
      7'b????100: dec_s = 4'd3;
      7'b???1000: dec_s = 4'd4;
      7'b??10000: dec_s = 4'd5;
      7'b?100000: dec_s = 4'd6;
      7'b1000000: dec_s = 4'd7;
      default:    dec_s = 4'd0;
    endcase
  end

  // Playback FSM next-state and next-output logic
  always_comb begin
    state_s = state_r;
    note_s  = note_out;
    pend_s  = pend_r;
    valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && (dec_s != 4'd0)) begin
          state_s = PLAYING;
          note_s  = dec_s;
          valid_s = 1'b1;
        end else begin
          state_s = IDLE;
          note_s  = 4'd0;
        end
      end
      PLAYING: begin
        if (!enable || (dec_s == 4'd0)) begin
          state_s = IDLE;
          note_s  = 4'd0;
        end else if (dec_s != note_out) begin
          state_s = GAP;
          pend_s  = dec_s;
          note_s  = 4'd0;
        end else begin
          state_s = PLAYING;
          note_s  = note_out;
        end
      end
      GAP: begin
        // pend is informational only; the live decode decides the new note
        if (!enable || (dec_s == 4'd0)) begin
          state_s = IDLE;
          note_s  = 4'd0;
        end else begin
          state_s = PLAYING;
          note_s  = dec_s;
          valid_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        note_s  = 4'd0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      pend_r      <= 4'd0;
      note_out    <= 4'd0;
      note_valid  <= 1'b0;
      note_active <= 1'b0;
    end else begin
      state_r     <= state_s;
      pend_r      <= pend_s;
      note_out    <= note_s;
      note_valid  <= valid_s;
      note_active <= (state_s == PLAYING);
    end
  end

endmodule

// File: tb/tb_key_remap_decoder.sv
// Directed self-checking bench for key_remap_decoder with DEBOUNCE_CYCLES=4.
// Expected latencies follow the KEY_REMAP_DEBOUNCE_EN build setting.
module tb_key_remap_decoder;

`ifdef KEY_REMAP_DEBOUNCE_EN
  localparam int LAT        = 8;  // ticks from input change to note edge (k+7)
  localparam int BOUNCE_VAL = 1;
`else
  localparam int LAT        = 3;  // k+2 without debounce
  localparam int BOUNCE_VAL = 4;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [6:0] key_in;
  logic [6:0] km0, km1, km2, km3, km4, km5, km6;
  logic [3:0] note_out;
  logic       note_valid;
  logic       note_active;

  int checks   = 0;
  int failures = 0;

  key_remap_decoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .key_in(key_in),
    .key_mapping_0(km0), .key_mapping_1(km1), .key_mapping_2(km2),
    .key_mapping_3(km3), .key_mapping_4(km4), .key_mapping_5(km5),
    .key_mapping_6(km6),
    .note_out(note_out), .note_valid(note_valid), .note_active(note_active)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic default_maps();
    km0 = 7'b1000000; km1 = 7'b0100000; km2 = 7'b0010000; km3 = 7'b0001000;
    km4 = 7'b0000100; km5 = 7'b0000010; km6 = 7'b0000001;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; key_in = 7'd0;
    default_maps();
    #2;
    checks++; if (note_out !== 4'd0) begin failures++; $display("FAIL reset_note actual=%0d expected=0", note_out); end
    checks++; if (note_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%0b expected=0", note_valid); end
    checks++; if (note_active !== 1'b0) begin failures++; $display("FAIL reset_active actual=%0b expected=0", note_active); end
    tick(2);
    reset = 1'b0; enable = 1'b1;
    tick(10);
    checks++; if (note_out !== 4'd0) begin failures++; $display("FAIL idle_note actual=%0d expected=0", note_out); end
  endtask

  task automatic test_press();
    key_in = 7'b1000000;
    tick(LAT - 1);
    checks++; if (note_out !== 4'd0) begin failures++; $display("FAIL press_early actual=%0d expected=0", note_out); end
    tick(1);
    checks++; if (note_out !== 4'd1) begin failures++; $display("FAIL press_note actual=%0d expected=1", note_out); end
    checks++; if (note_valid !== 1'b1) begin failures++; $display("FAIL press_valid actual=%0b expected=1", note_valid); end
    checks++; if (note_active !== 1'b1) begin failures++; $display("FAIL press_active actual=%0b expected=1", note_active); end
    tick(1);
    checks++; if (note_valid !== 1'b0) begin failures++; $display("FAIL press_valid_single actual=%0b expected=0", note_valid); end
    checks++; if (note_out !== 4'd1) begin failures++; $display("FAIL press_hold actual=%0d expected=1", note_out); end
    key_in = 7'd0;
    tick(LAT - 1);
    checks++; if (note_out !== 4'd1) begin failures++; $display("FAIL release_early actual=%0d expected=1", note_out); end
    tick(1);
    checks++; if (note_out !== 4'd0) begin failures++; $display("FAIL release_note actual=%0d expected=0", note_out); end
    checks++; if (note_active !== 1'b0) begin failures++; $display("FAIL release_active actual=%0b expected=0", note_active); end
    tick(3);
  endtask

  task automatic test_bounce();
    int vcount;
    vcount = 0;
    for (int p = 0; p < 6; p++) begin
      key_in = (p % 2 == 0) ? 7'b0000001 : 7'b0000000;
      for (int c = 0; c < 2; c++) begin
        tick(1);
        vcount += int'(note_valid);
      end
    end
    key_in = 7'b0000001;
    for (int c = 0; c < LAT - 1; c++) begin
      tick(1);
      vcount += int'(note_valid);
    end
    checks++; if (note_out !== 4'd0) begin failures++; $display("FAIL bounce_early actual=%0d expected=0", note_out); end
    tick(1);
    vcount += int'(note_valid);
    checks++; if (note_out !== 4'd7) begin failures++; $display("FAIL bounce_note actual=%0d expected=7", note_out); end
    for (int c = 0; c < 3; c++) begin
      tick(1);
      vcount += int'(note_valid);
    end
    checks++; if (vcount != BOUNCE_VAL) begin failures++; $display("FAIL bounce_valid_count actual=%0d expected=%0d", vcount, BOUNCE_VAL); end
    key_in = 7'd0;
    tick(LAT + 2);
  endtask

  task automatic test_retrigger();
    key_in = 7'b1000000;
    tick(LAT + 1);
    checks++; if (note_out !== 4'd1) begin failures++; $display("FAIL retrig_first actual=%0d expected=1", note_out); end
    key_in = 7'b0100000;
    tick(LAT - 1);
    checks++; if (note_out !== 4'd1) begin failures++; $display("FAIL retrig_before actual=%0d expected=1", note_out); end
    tick(1);
    checks++; if (note_out !== 4'd0) begin failures++; $display("FAIL retrig_gap_note actual=%0d expected=0", note_out); end
    checks++; if (note_active !== 1'b0) begin failures++; $display("FAIL retrig_gap_active actual=%0b expected=0", note_active); end
    checks++; if (note_valid !== 1'b0) begin failures++; $display("FAIL retrig_gap_valid actual=%0b expected=0", note_valid); end
    tick(1);
    checks++; if (note_out !== 4'd2) begin failures++; $display("FAIL retrig_second actual=%0d expected=2", note_out); end
    checks++; if (note_valid !== 1'b1) begin failures++; $display("FAIL retrig_valid actual=%0b expected=1", note_valid); end
    checks++; if (note_active !== 1'b1) begin failures++; $display("FAIL retrig_active actual=%0b expected=1", note_active); end
    tick(1);
    checks++; if (note_valid !== 1'b0) begin failures++; $display("FAIL retrig_valid_single actual=%0b expected=0", note_valid); end
    key_in = 7'd0;
    tick(LAT + 2);
  endtask

  task automatic test_priority_remap();
    int bad_note;
    int vcount;
    key_in = 7'b1000001;
    tick(LAT + 1);
    checks++; if (note_out !== 4'd1) begin failures++; $display("FAIL prio_lowest actual=%0d expected=1", note_out); end
    km0 = 7'b0000001; km6 = 7'b1000000; key_in = 7'b0000001;
    bad_note = 0; vcount = 0;
    for (int c = 0; c < LAT + 3; c++) begin
      tick(1);
      if (note_out !== 4'd1) bad_note++;
      vcount += int'(note_valid);
    end
    checks++; if (bad_note != 0) begin failures++; $display("FAIL remap_hold actual=%0d bad cycles expected=0", bad_note); end
    checks++; if (vcount != 0) begin failures++; $display("FAIL remap_no_valid actual=%0d expected=0", vcount); end
    km0 = 7'b0000000;
    tick(1);
    checks++; if (note_out !== 4'd0) begin failures++; $display("FAIL zero_map_rest actual=%0d expected=0", note_out); end
    km6 = 7'b0000001;
    tick(1);
    checks++; if (note_out !== 4'd7) begin failures++; $display("FAIL remap_note7 actual=%0d expected=7", note_out); end
    checks++; if (note_valid !== 1'b1) begin failures++; $display("FAIL remap_valid actual=%0b expected=1", note_valid); end
    default_maps();
    key_in = 7'd0;
    tick(LAT + 2);
    checks++; if (note_out !== 4'd0) begin failures++; $display("FAIL remap_release actual=%0d expected=0", note_out); end
  endtask

  task automatic test_enable();
    key_in = 7'b0010000;
    tick(LAT + 1);
    checks++; if (note_out !== 4'd3) begin failures++; $display("FAIL en_note actual=%0d expected=3", note_out); end
    enable = 1'b0;
    tick(1);
    checks++; if (note_out !== 4'd0) begin failures++; $display("FAIL en_off_note actual=%0d expected=0", note_out); end
    checks++; if (note_valid !== 1'b0) begin failures++; $display("FAIL en_off_valid actual=%0b expected=0", note_valid); end
    checks++; if (note_active !== 1'b0) begin failures++; $display("FAIL en_off_active actual=%0b expected=0", note_active); end
    tick(3);
    checks++; if (note_out !== 4'd0) begin failures++; $display("FAIL en_off_stay actual=%0d expected=0", note_out); end
    enable = 1'b1;
    tick(1);
    checks++; if (note_out !== 4'd3) begin failures++; $display("FAIL en_on_note actual=%0d expected=3", note_out); end
    checks++; if (note_valid !== 1'b1) begin failures++; $display("FAIL en_on_valid actual=%0b expected=1", note_valid); end
    tick(1);
    checks++; if (note_valid !== 1'b0) begin failures++; $display("FAIL en_on_valid_single actual=%0b expected=0", note_valid); end
  endtask

  task automatic test_reset_mid();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (note_out !== 4'd0) begin failures++; $display("FAIL rst_mid_note actual=%0d expected=0", note_out); end
    checks++; if (note_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid actual=%0b expected=0", note_valid); end
    checks++; if (note_active !== 1'b0) begin failures++; $display("FAIL rst_mid_active actual=%0b expected=0", note_active); end
    tick(1);
    reset = 1'b0;
    tick(LAT - 1);
    checks++; if (note_out !== 4'd0) begin failures++; $display("FAIL rst_relat_early actual=%0d expected=0", note_out); end
    tick(1);
    checks++; if (note_out !== 4'd3) begin failures++; $display("FAIL rst_relat_note actual=%0d expected=3", note_out); end
    checks++; if (note_valid !== 1'b1) begin failures++; $display("FAIL rst_relat_valid actual=%0b expected=1", note_valid); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_retrigger();
    test_priority_remap();
    test_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_remap_decoder.md
# key_remap_decoder

Play-mode front end that turns raw key switches into note numbers using the seven key mappings programmed during adjustment mode. It synchronizes and debounces `key_in`, decodes the debounced key vector against `key_mapping_0..6`, and runs a small playback state machine. That state machine drives a registered note number plus start strobes to the tone generator. It sits between the board switches, the adjustment-mode mapping registers and the audio/note path.

## Interface
- `DEBOUNCE_CYCLES`, default 200000: consecutive stable cycles required before a key vector is accepted (≥2). Benches use 4.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  play mode. Low forces rest.
- `key_in`  in  7  raw asynchronous key switches, active-high.
- `key_mapping_0` .. `key_mapping_6`  in  7 each  physical-key mask for notes 1..7, held static by the mapping owner.
- `note_out`  out  4  registered note. 0 = rest, 1..7 = note.
- `note_valid`  out  1  one-cycle pulse on every entry to PLAYING.
- `note_active`  out  1  high while in PLAYING.

## Operation
- Sync: two flops, `sync1 <= key_in`, `s <= sync1`.
- Debounce:
  - `cand <= s` every cycle.
  - `cnt <= 0` if `s != cand`, else `cnt + 1`, saturating at `DEBOUNCE_CYCLES-1`.
  - When `cnt == DEBOUNCE_CYCLES-1`, `deb <= cand`.
  - `cnt` width is `$clog2(DEBOUNCE_CYCLES)`.
- Decode (combinational):
  - `hit_i = |(deb & key_mapping_i)`.
  - `dec` = i+1 for the lowest i with `hit_i`, else 0.
  - Multiple keys pressed: the lowest note wins.
  - An all-zero mapping never hits.
  - A mapping change is treated exactly like a key change.
- States: IDLE, PLAYING, GAP. The state register is 2 bits.
- IDLE (`note_out=0`, `note_active=0`):
  - If `enable && dec!=0`: go to PLAYING, `note_out<=dec`, `note_valid<=1`.
- PLAYING:
  - If `!enable || dec==0`: go to IDLE, `note_out<=0`.
  - Else if `dec != note_out`: go to GAP, `pend<=dec`, `note_out<=0`.
  - Else hold.
- GAP (one-cycle articulation rest, `note_out=0`, `note_active=0`):
  - If `!enable || dec==0`: go to IDLE.
  - Else go to PLAYING with `note_out<=dec`, `note_valid<=1`. `pend` is only a debug copy; current `dec` wins.
- `note_valid` is high only in the cycle after a transition into PLAYING. It is never high for two consecutive cycles.
- Reset values: `note_out=0`, `note_valid=0`, `note_active=0`, state IDLE, and `sync1`, `s`, `cand`, `cnt`, `deb`, `pend` all 0.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency with debounce: `key_in` settled before edge k gives:
  - `s` valid after edge k+1.
  - `deb` updated at edge k+DEBOUNCE_CYCLES+2.
  - `note_out`/`note_valid` at edge k+DEBOUNCE_CYCLES+3. With D=4 that is 7 edges.
- Release latency is the same as press latency.
- Any `s` change restarts the count. A vector shorter than `DEBOUNCE_CYCLES` stable cycles never reaches `deb`.
- Retrigger costs exactly one rest cycle (GAP).
- `enable` falling forces IDLE at the next edge, with no `note_valid`. Debounce keeps running while disabled.
- `enable` rising with `deb` already stable gives `note_valid` at the next edge.
- Reset mid-operation clears all outputs immediately (async). The first note after release needs the full latency.

## Configuration
- `KEY_REMAP_DEBOUNCE_EN` defined: debounce stage as above.
- Not defined:
  - `cand`/`cnt` are removed and `deb = s` combinationally.
  - Latency is edge k+2 for `note_out`.
  - FSM, decode, GAP and reset behaviour are unchanged.

## Test plan
All scenarios use D=4 and mappings `key_mapping_0=7'b1000000` … `key_mapping_6=7'b0000001`.
- Press: `key_in=7'b1000000` settled before edge k -> `note_out=1` and a single `note_valid` pulse at edge k+7, `note_active=1`. Release -> `note_out=0` at 7 edges after release.
- Bounce: toggle `key_in` between 0 and `7'b0000001` every 2 cycles for 12 cycles, then hold -> exactly one `note_valid`, `note_out=7`, 7 edges after the last toggle.
- Retrigger: hold `7'b1000000`, switch to `7'b0100000` -> `note_out` goes 1 -> 0 (one cycle, `note_active=0`) -> 2. `note_valid` pulses only on entry to 2.
- Priority/remap: `key_in=7'b1000001` -> `note_out=1`. Then set `key_mapping_0=7'b0000001`, `key_mapping_6=7'b1000000`, `key_in=7'b0000001` -> `note_out=1`.
- Enable: deassert while playing -> `note_out=0` next edge, no `note_valid`. Reassert with key held -> `note_out` restored and `note_valid` pulse at the next edge.
- Reset: assert `reset` mid-PLAYING, asynchronously between edges -> `note_out`, `note_valid`, `note_active` = 0 immediately. After release with key held -> note returns after the full 7-edge latency.
